mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 43 ++++
 rtl/mdu_ctrl_if.sv | 36 +++
 rtl/mdu_core.sv | 50 +++++
 rtl/mdu_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared constants and types for the HI/LO multiply-divide
// controller.
//   - md_op_e     : EX-stage MDU operation encoding
//   - mdu_state_e : controller FSM state encoding
//   - default busy-cycle counts for multiply and divide
//   - small helpers that classify an md_op value
package mdu_ctrl_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } mdu_state_e;

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Operations that occupy the unit for several cycles.
  function automatic logic is_multicycle_op(input logic [2:0] op);
    return is_mult_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: pipeline-side bundle of the multiply-divide controller.
//   start/md_op/operand1/operand2 : EX-stage request (start is the valid)
//   md_use_id                     : ID-stage instruction touches HI/LO
//   rd_hi                         : md_out select (1 = HI, 0 = LO)
//   busy/stall_req                : unit occupied / freeze-the-front-end request
//   HI/LO/md_out                  : architectural registers and read mux
//
// Handshake: start is a single-cycle valid qualified by md_op; the unit is
// ready whenever busy is 0. A start while busy is dropped without effect, so
// the issuing pipeline must use stall_req to hold back the next MDU instruction.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic            start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            md_use_id;
  logic            rd_hi;
  logic            busy;
  logic            stall_req;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;
  logic [XLEN-1:0] md_out;

  modport master (
    output start, md_op, operand1, operand2, md_use_id, rd_hi,
    input  busy, stall_req, HI, LO, md_out
  );

  modport slave (
    input  start, md_op, operand1, operand2, md_use_id, rd_hi,
    output busy, stall_req, HI, LO, md_out
  );

endinterface

// File: rtl/mdu_core.sv
// mdu_core: purely combinational 32x32 arithmetic for the controller.
//   a, b        : operands (dividend/multiplicand = a)
//   is_signed   : treat operands as two's complement
//   mul_res     : 64-bit product {hi, lo}
//   div_res     : {remainder, quotient}; quotient truncates toward zero and
//                 the remainder carries the dividend's sign
//   div_by_zero : b == 0 (div_res is then forced to 0)
module mdu_core
  import mdu_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              is_signed,
  output logic [2*XLEN-1:0] mul_res,
  output logic [2*XLEN-1:0] div_res,
  output logic              div_by_zero
);

  logic [2*XLEN-1:0] a_ext, b_ext;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    // A single 64-bit multiply covers both flavours: the low 64 bits of the
    // product of the extended operands are the exact 32x32 result.
    a_ext   = {{XLEN{is_signed & a[XLEN-1]}}, a};
    b_ext   = {{XLEN{is_signed & b[XLEN-1]}}, b};
    mul_res = a_ext * b_ext;

    // Signed divide works on magnitudes and fixes the signs afterwards; this
    // keeps the most-negative dividend well defined (its magnitude fits
    // unsigned).
    a_neg       = is_signed & a[XLEN-1];
    b_neg       = is_signed & b[XLEN-1];
    a_mag       = a_neg ? (~a + 32'd1) : a;
    b_mag       = b_neg ? (~b + 32'd1) : b;
    div_by_zero = (b == '0);
    if (div_by_zero) begin
      q_mag = '0;
      r_mag = '0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
    div_res = {rem, quot};
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply-divide sequencing for a MIPS-style pipeline.
//   clk       : sole clock, rising edge
//   reset     : asynchronous, active low
//   bus       : mdu_ctrl_if slave (request, stall, HI/LO, md_out)
//   dbg_state : current FSM state
// MULT/MULTU and DIV/DIVU compute their result at the start edge into a
// pending register, then hold busy for MULT_CYCLES/DIV_CYCLES cycles before
// committing it to HI/LO. MTHI/MTLO write in one cycle.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   bus,
  output mdu_state_e  dbg_state
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] pend_q, pend_d;   // {hi, lo} awaiting commit
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*XLEN-1:0] mul_res, div_res;
  logic              div_by_zero;
  logic              op_signed;

  assign op_signed = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);

  mdu_core u_core (
    .a           (bus.operand1),
    .b           (bus.operand2),
    .is_signed   (op_signed),
    .mul_res     (mul_res),
    .div_res     (div_res),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_mult_op(bus.md_op)) begin
            pend_d  = mul_res;
            cnt_d   = MULT_LOAD;
            state_d = S_MUL_RUN;
          end else if (is_div_op(bus.md_op)) begin
            // A zero divisor still costs the full divide latency; pending is
            // loaded with the current HI/LO so the commit is a no-op.
            pend_d  = div_by_zero ? {hi_q, lo_q} : div_res;
            cnt_d   = DIV_LOAD;
            state_d = S_DIV_RUN;
          end else if (bus.md_op == MD_MTHI) begin
            hi_d = bus.operand1;
          end else if (bus.md_op == MD_MTLO) begin
            lo_d = bus.operand1;
          end
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        // Requests arriving here are dropped: nothing reads bus.start.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          hi_d    = pend_q[2*XLEN-1:XLEN];
          lo_d    = pend_q[XLEN-1:0];
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.stall_req = bus.md_use_id &
                         (bus.busy | (bus.start & is_multicycle_op(bus.md_op)));
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.md_out    = bus.rd_hi ? hi_q : lo_q;
  assign dbg_state     = state_q;

endmodule
